// File: rtl/uart_rx_axis.sv
// UART receiver feeding a byte-wide AXI4-Stream master.
// Packets close with tlast after a configurable line-idle gap.
module uart_rx_axis #(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_TYPE = 0,
  parameter int IDLE_BITS   = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  input  logic [15:0]           prescale,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  output logic                  parity_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [3:0]  LAST_BIT = 4'(DATA_WIDTH - 1);
  localparam logic [31:0] IDLE_W   = 32'(IDLE_BITS);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx;

  state_t                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [15:0]            pre_q, pre_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_WIDTH-1:0]  shr_q, shr_d;
  logic                   par_q, par_d;

  logic                   tick;
  logic                   start_det;
  logic                   done;
  logic                   ferr;
  logic                   perr;
  logic                   par_x;
  logic                   par_bad;
  logic                   byte_err;

  logic [DATA_WIDTH-1:0]  out_data_q;
  logic                   out_valid_q;
  logic                   out_last_q;
  logic                   out_user_q;
  logic [DATA_WIDTH-1:0]  pend_data_q;
  logic                   pend_valid_q;
  logic                   pend_user_q;
  logic [31:0]            idle_q;
  logic [31:0]            idle_limit;
  logic                   idle_hit;
  logic                   out_free;
  logic                   ovr_q;
  logic                   fe_q;
  logic                   pe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rx = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      bit_q   <= '0;
      shr_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      bit_q   <= bit_d;
      shr_q   <= shr_d;
      par_q   <= par_d;
    end
  end

  assign tick  = (cnt_q == 16'd0);
  assign par_x = (^shr_q) ^ par_q;

  assign par_bad = (PARITY_TYPE == 1) ? par_x  :
                   (PARITY_TYPE == 2) ? ~par_x :
                   1'b0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pre_d     = pre_q;
    bit_d     = bit_q;
    shr_d     = shr_q;
    par_d     = par_q;
    start_det = 1'b0;
    done      = 1'b0;
    ferr      = 1'b0;
    perr      = 1'b0;
    if (state_q != S_IDLE) begin
      cnt_d = tick ? pre_q - 16'd1 : cnt_q - 16'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (!rx) begin
          state_d   = S_START;
          cnt_d     = (prescale >> 1) - 16'd1;
          pre_d     = prescale;
          start_det = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = rx ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          shr_d = {rx, shr_q[DATA_WIDTH-1:1]};
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY_TYPE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          par_d   = rx;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          done    = 1'b1;
          ferr    = ~rx;
          perr    = par_bad;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign byte_err   = ferr | perr;
  assign out_free   = ~out_valid_q | m_axis_tready;
  assign idle_limit = IDLE_W * {16'd0, pre_q};
  assign idle_hit   = (idle_q >= idle_limit);

  // Later assignments win: a load overrides the handshake clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_user_q   <= 1'b0;
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      pend_user_q  <= 1'b0;
      idle_q       <= '0;
      ovr_q        <= 1'b0;
      fe_q         <= 1'b0;
      pe_q         <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      fe_q  <= done & ferr;
      pe_q  <= done & perr;
      if (out_valid_q && m_axis_tready) begin
        out_valid_q <= 1'b0;
      end
      if (IDLE_BITS == 0) begin
        if (done) begin
          if (out_free) begin
            out_valid_q <= 1'b1;
            out_data_q  <= shr_q;
            out_last_q  <= 1'b1;
            out_user_q  <= byte_err;
          end else begin
            ovr_q <= 1'b1;
          end
        end
      end else if (done) begin
        idle_q <= '0;
        if (!pend_valid_q) begin
          pend_valid_q <= 1'b1;
          pend_data_q  <= shr_q;
          pend_user_q  <= byte_err;
        end else if (out_free) begin
          out_valid_q <= 1'b1;
          out_data_q  <= pend_data_q;
          out_last_q  <= 1'b0;
          out_user_q  <= pend_user_q;
          pend_data_q <= shr_q;
          pend_user_q <= byte_err;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (pend_valid_q) begin
        if (start_det) begin
          idle_q <= '0;
        end else if (state_q == S_IDLE) begin
          if (idle_hit) begin
            if (out_free) begin
              out_valid_q  <= 1'b1;
              out_data_q   <= pend_data_q;
              out_last_q   <= 1'b1;
              out_user_q   <= pend_user_q;
              pend_valid_q <= 1'b0;
            end
          end else if (idle_q != '1) begin
            idle_q <= idle_q + 32'd1;
          end
        end
      end
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = out_user_q;
  assign busy          = (state_q != S_IDLE);
  assign overrun_error = ovr_q;
  assign frame_error   = fe_q;
  assign parity_error  = pe_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed bench for uart_rx_axis: default build plus an
// even-parity build with no idle stage.
module tb_uart_rx_axis;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic        rxd_p;
  logic [15:0] prescale;
  logic        tready;
  logic        tready_p;

  logic [7:0]  tdata, tdata_p;
  logic        tvalid, tvalid_p;
  logic        tlast, tlast_p;
  logic        tuser, tuser_p;
  logic        busy, busy_p;
  logic        ovr, ovr_p;
  logic        fe, fe_p;
  logic        pe, pe_p;

  int n_chk = 0;
  int n_err = 0;
  int n_fe = 0;
  int n_pe = 0;
  int n_ovr = 0;
  int n_pe_p = 0;
  int n_fe_p = 0;

  logic [9:0] q[$];
  logic [9:0] qp[$];

  always #5 clk = ~clk;

  uart_rx_axis dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .prescale      (prescale),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .m_axis_tuser  (tuser),
    .busy          (busy),
    .overrun_error (ovr),
    .frame_error   (fe),
    .parity_error  (pe)
  );

  uart_rx_axis #(
    .PARITY_TYPE (1),
    .IDLE_BITS   (0)
  ) dut_p (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd_p),
    .prescale      (prescale),
    .m_axis_tdata  (tdata_p),
    .m_axis_tvalid (tvalid_p),
    .m_axis_tready (tready_p),
    .m_axis_tlast  (tlast_p),
    .m_axis_tuser  (tuser_p),
    .busy          (busy_p),
    .overrun_error (ovr_p),
    .frame_error   (fe_p),
    .parity_error  (pe_p)
  );

  always @(negedge clk) begin
    if (tvalid && tready) q.push_back({tuser, tlast, tdata});
    if (tvalid_p && tready_p) qp.push_back({tuser_p, tlast_p, tdata_p});
    if (fe) n_fe++;
    if (pe) n_pe++;
    if (ovr) n_ovr++;
    if (pe_p) n_pe_p++;
    if (fe_p) n_fe_p++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_bit(input bit sel, input logic v);
    if (sel) rxd_p = v;
    else rxd = v;
    wait_cyc(16);
  endtask

  task automatic send(input bit sel, input logic [7:0] d,
                      input bit use_par, input logic par,
                      input logic stop);
    put_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) put_bit(sel, d[i]);
    if (use_par) put_bit(sel, par);
    put_bit(sel, stop);
    if (sel) rxd_p = 1'b1;
    else rxd = 1'b1;
  endtask

  task automatic exp_beat(input string tag, input bit sel,
                          input logic [7:0] d, input logic l,
                          input logic u);
    logic [9:0] b;
    if ((sel ? qp.size() : q.size()) == 0) begin
      chk({tag, ".present"}, 32'd0, 32'd1);
    end else begin
      b = sel ? qp.pop_front() : q.pop_front();
      chk({tag, ".data"}, 32'(b[7:0]), 32'(d));
      chk({tag, ".last"}, 32'(b[8]), 32'(l));
      chk({tag, ".user"}, 32'(b[9]), 32'(u));
    end
  endtask

  initial begin
    rst      = 1'b1;
    rxd      = 1'b1;
    rxd_p    = 1'b1;
    prescale = 16'd16;
    tready   = 1'b1;
    tready_p = 1'b1;
    wait_cyc(5);
    chk("rst.tvalid", 32'(tvalid), 32'd0);
    chk("rst.tdata", 32'(tdata), 32'd0);
    chk("rst.tlast", 32'(tlast), 32'd0);
    chk("rst.tuser", 32'(tuser), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.errs", 32'({ovr, fe, pe}), 32'd0);
    rst = 1'b0;
    wait_cyc(3);

    send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    chk("t1.gap", 32'(q.size()), 32'd0);
    wait_cyc(200);
    exp_beat("t1", 1'b0, 8'h55, 1'b1, 1'b0);

    send(1'b0, 8'hA1, 1'b0, 1'b0, 1'b1);
    send(1'b0, 8'hB2, 1'b0, 1'b0, 1'b1);
    send(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    wait_cyc(200);
    chk("t2.count", 32'(q.size()), 32'd3);
    exp_beat("t2a", 1'b0, 8'hA1, 1'b0, 1'b0);
    exp_beat("t2b", 1'b0, 8'hB2, 1'b0, 1'b0);
    exp_beat("t2c", 1'b0, 8'hC3, 1'b1, 1'b0);
    chk("t2.errs", 32'(n_fe + n_pe + n_ovr), 32'd0);

    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    wait_cyc(220);
    chk("t3.fe", 32'(n_fe), 32'd1);
    exp_beat("t3", 1'b0, 8'h3C, 1'b1, 1'b1);
    chk("t3.extra", 32'(q.size()), 32'd0);

    tready = 1'b0;
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    send(1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
    wait_cyc(220);
    chk("t4.ovr", 32'(n_ovr), 32'd1);
    chk("t4.tvalid", 32'(tvalid), 32'd1);
    chk("t4.tdata", 32'(tdata), 32'h11);
    chk("t4.tlast", 32'(tlast), 32'd0);
    tready = 1'b1;
    wait_cyc(6);
    chk("t4.count", 32'(q.size()), 32'd2);
    exp_beat("t4a", 1'b0, 8'h11, 1'b0, 1'b0);
    exp_beat("t4b", 1'b0, 8'h22, 1'b1, 1'b0);

    rxd = 1'b0;
    wait_cyc(3);
    rxd = 1'b1;
    wait_cyc(2);
    chk("t5.busy_on", 32'(busy), 32'd1);
    wait_cyc(40);
    chk("t5.busy_off", 32'(busy), 32'd0);
    wait_cyc(200);
    chk("t5.nobeat", 32'(q.size()), 32'd0);
    chk("t5.noerr", 32'(n_fe + n_pe), 32'd1);

    send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_cyc(4);
    exp_beat("tp.good", 1'b1, 8'h07, 1'b1, 1'b0);
    send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_cyc(4);
    chk("tp.pe", 32'(n_pe_p), 32'd1);
    chk("tp.fe", 32'(n_fe_p), 32'd0);
    exp_beat("tp.bad", 1'b1, 8'h07, 1'b1, 1'b1);

    put_bit(1'b0, 1'b0);
    put_bit(1'b0, 1'b1);
    put_bit(1'b0, 1'b0);
    rst = 1'b1;
    rxd = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(300);
    chk("t6.nobeat", 32'(q.size()), 32'd0);
    chk("t6.busy", 32'(busy), 32'd0);
    chk("t6.tvalid", 32'(tvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
